// File: rtl/twos_complement_seq.sv
// Multi-byte two's-complement negator: one byte-wide complement datapath
// (s = ~p + carry_in) walked LSB-first across the latched operand.
module twos_complement_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  out_zero,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int DATA_W = 8 * NBYTES;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_opnd;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_zero_acc;

    logic                w_accept;
    logic                w_last;
    logic [7:0]          w_byte;
    logic [7:0]          w_res;
    logic                w_cout;
    logic                w_byte_zero;

    // Bit 8 of the result is the carry into the next byte: set only when
    // ~b is all ones and carry_in is 1, i.e. b == 0 with carry still alive.
    function automatic logic [8:0] cpl_byte(input logic [7:0] b, input logic cin);
        cpl_byte = {1'b0, ~b} + {8'd0, cin};
    endfunction

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_byte      = r_opnd[8*r_idx +: 8];
    assign {w_cout, w_res} = cpl_byte(w_byte, r_carry);
    assign w_byte_zero = (w_byte == 8'h00);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)  w_state_next = S_RUN;
            S_RUN:  if (w_last)    w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    // Operand is held untouched during RUN; result bytes fill out_data in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_carry    <= 1'b1;
            r_zero_acc <= 1'b1;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opnd     <= in_data;
                        r_idx      <= '0;
                        r_carry    <= 1'b1;
                        r_zero_acc <= 1'b1;
                    end
                end
                S_RUN: begin
                    out_data[8*r_idx +: 8] <= w_res;
                    r_carry    <= w_cout;
                    r_zero_acc <= r_zero_acc & w_byte_zero;
                    if (w_last) begin
                        r_idx    <= '0;
                        out_zero <= r_zero_acc & w_byte_zero;
                        out_ovf  <= w_byte[7] & w_res[7];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twos_complement_seq.sv
// Self-checking bench for twos_complement_seq: directed corner cases plus
// random operands against an arithmetic negation model (NBYTES=4 and NBYTES=1).
module tb_twos_complement_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        out_zero, out_ovf, busy;

    logic        b_reset;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic        b_out_zero, b_out_ovf, b_busy;

    int errors = 0;
    int checks = 0;

    twos_complement_seq #(.NBYTES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_ovf(out_ovf), .busy(busy)
    );

    twos_complement_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .reset(b_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_zero(b_out_zero), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] neg32(input logic [31:0] a);
        return 32'd0 - a;
    endfunction

    // One full transaction on the 4-byte DUT, starting and ending at a negedge in IDLE.
    task automatic do_op(input logic [31:0] a, input int stall, input bit poke);
        int n;
        logic [31:0] exp;
        exp = neg32(a);
        check("idle_in_ready", in_ready, 1);
        in_data  = a;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("run_in_ready", in_ready, 0);
        check("run_busy", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 4);
        check("data", out_data, exp);
        check("zero", out_zero, (a == 32'd0));
        check("ovf", out_ovf, (a == 32'h8000_0000));
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, exp);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_data_held", out_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ops [3];
        logic [31:0] a;
        logic [7:0]  e8;
        int k, got, last;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_zero", out_zero, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);

        // Directed values including carry-chain and extreme operands
        do_op(32'h0000_0001, 0, 0);
        do_op(32'h0000_0000, 0, 0);
        do_op(32'h8000_0000, 0, 0);
        do_op(32'h0000_0100, 0, 0);
        do_op(32'hFFFF_FFFF, 0, 0);
        do_op(32'h7FFF_FFFF, 1, 0);

        // Backpressure with an ignored in_valid pulse during DONE
        do_op(32'h0000_00FF, 5, 1);

        // Reset on the second RUN cycle drops the operation
        in_data = 32'h1234_5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        do_op(32'h0000_0005, 0, 0);

        // Back-to-back with in_valid and out_ready tied high
        ops[0] = 32'd3; ops[1] = 32'd7; ops[2] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        k = 0; got = 0; last = 0;
        for (int c = 0; c < 60 && got < 3; c++) begin
            if (out_valid) begin
                check("b2b_data", out_data, neg32(ops[got]));
                if (got > 0) check("b2b_period", c - last, 6);
                last = c;
                got++;
            end
            if (in_ready) begin
                if (k < 3) begin
                    in_data  = ops[k];
                    in_valid = 1'b1;
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", got, 3);
        check("b2b_idle", in_ready, 1);

        // Random operands, occasionally forced to corner values
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = a & 32'hFFFF_0000;
                2: a = a & 32'h0000_00FF;
                default: ;
            endcase
            do_op(a, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // NBYTES=1 exhaustive sweep with out_ready tied high
        for (int v = 0; v < 256; v++) begin
            e8 = 8'(v);
            b_in_data  = e8;
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            @(negedge clk);
            check("n1_valid", b_out_valid, 1);
            check("n1_data", b_out_data, 8'(8'd0 - e8));
            check("n1_zero", b_out_zero, (v == 0));
            check("n1_ovf", b_out_ovf, (v == 128));
            @(negedge clk);
            check("n1_idle", b_in_ready, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
